// File: rtl/line_feeder_credit_ctrl_if.sv
// ---------------------------------------------------------------------------
// line_feeder_credit_ctrl_if
//
// Purpose:
//   Ready/valid pixel stream carrying raw 8-bit pixels into the line feeder.
//   A beat transfers on a rising clock edge where s_tvalid && s_tready.
//
// Signals:
//   s_tdata   [7:0]  pixel value, driven by the source
//   s_tvalid         pixel valid, driven by the source
//   s_tready         pixel accepted, driven by the sink
//
// Modports:
//   master  - pixel source (drives data/valid, observes ready)
//   slave   - pixel sink   (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface line_feeder_credit_ctrl_if;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;

    modport master (
        output s_tdata,
        output s_tvalid,
        input  s_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        output s_tready
    );
endinterface

// File: rtl/line_feeder_credit_ctrl.sv
// ---------------------------------------------------------------------------
// line_feeder_credit_ctrl
//
// Purpose:
//   Upstream companion of the 4-line buffer controller. Accepts a raw pixel
//   stream and writes it into the line buffer bank one line at a time.
//   Writing is throttled by line credits: BUF_LINES lines may be written up
//   front, and each i_line_done pulse from the consumer returns one credit.
//   Once every line is written and the consumer has reported all of its
//   output rows, o_frame_done pulses and the block returns to idle.
//
// Optional feature (compile-time macro LINE_FEEDER_ZERO_PAD_EN):
//   When defined, one all-zero line is injected before the first input line
//   and one after the last. Pad lines obey the same credit rule as input
//   lines, but the input stream is stalled (s_tready=0) while they are
//   emitted. When undefined, no pad logic is built.
//
// Parameters:
//   IMAGE_WIDTH   pixels per line
//   IMAGE_HEIGHT  input lines per frame (minimum 3)
//   BUF_LINES     line-buffer depth in lines; initial credit count
//
// Ports:
//   clk                 clock
//   reset_n             synchronous active-low reset
//   i_start             single-cycle frame start pulse (honoured in IDLE only)
//   pix_in              ready/valid pixel input (slave side)
//   o_pixel_data        pixel to the line buffer bank
//   o_pixel_data_valid  write strobe to the line buffer bank
//   i_line_done         single-cycle pulse: consumer freed one line
//   o_busy              high from the cycle after i_start until o_frame_done
//   o_frame_done        single-cycle end-of-frame pulse
//   o_err               sticky: i_line_done with all credits home, or in IDLE
// ---------------------------------------------------------------------------
module line_feeder_credit_ctrl #(
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512,
    parameter int BUF_LINES    = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            i_start,
    line_feeder_credit_ctrl_if.slave        pix_in,
    output logic [7:0]                      o_pixel_data,
    output logic                            o_pixel_data_valid,
    input  logic                            i_line_done,
    output logic                            o_busy,
    output logic                            o_frame_done,
    output logic                            o_err
);

    // -----------------------------------------------------------------------
    // Derived sizes and constants
    // -----------------------------------------------------------------------
    localparam int PIX_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int LINE_W = $clog2(IMAGE_HEIGHT + 3);
    localparam int CRED_W = $clog2(BUF_LINES + 1);

`ifdef LINE_FEEDER_ZERO_PAD_EN
    localparam int LINES_TOTAL = IMAGE_HEIGHT + 2;
`else
    localparam int LINES_TOTAL = IMAGE_HEIGHT;
`endif
    // The 3-line consumer yields two fewer output rows than lines written.
    localparam int DONE_TOTAL = LINES_TOTAL - 2;

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(IMAGE_WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_TOTAL - 1);
    localparam logic [LINE_W-1:0] DONE_END  = LINE_W'(DONE_TOTAL);
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(BUF_LINES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State and counters
    // -----------------------------------------------------------------------
    state_t              state_q;
    state_t              state_d;
    logic [PIX_W-1:0]    pix_ctr;
    logic [LINE_W-1:0]   line_ctr;
    logic [LINE_W-1:0]   done_ctr;
    logic [CRED_W-1:0]   credits;

    // -----------------------------------------------------------------------
    // Decoded conditions
    // -----------------------------------------------------------------------
    logic has_credit;
    logic pad_line;
    logic ready;
    logic pad_wr;
    logic accept;
    logic wr;
    logic wrap;
    logic last_line;
    logic line_ret;
    logic drain_done;

    assign has_credit = (credits != '0);

`ifdef LINE_FEEDER_ZERO_PAD_EN
    // First and last lines of the frame are synthesised zero lines.
    assign pad_line = (line_ctr == '0) || (line_ctr == LINE_LAST);
`else
    assign pad_line = 1'b0;
`endif

    assign accept     = pix_in.s_tvalid && ready;
    assign wr         = accept || pad_wr;
    assign wrap       = wr && (pix_ctr == PIX_LAST);
    assign last_line  = (line_ctr == LINE_LAST);
    assign line_ret   = i_line_done && (state_q != IDLE);
    assign drain_done = (state_q == DRAIN) && (done_ctr == DONE_END);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every always_comb output gets a default on entry so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // Leaving on the final wrap drops s_tready on the very cycle
                // the wrap is registered.
                if (wrap && last_line) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic
    //   s_tready depends only on registered state, never on s_tvalid, so the
    //   source can not form a combinational loop through this block.
    // -----------------------------------------------------------------------
    always_comb begin
        ready  = 1'b0;
        pad_wr = 1'b0;
        if (state_q == STREAM) begin
            ready  = has_credit && !pad_line;
            pad_wr = has_credit &&  pad_line;
        end
    end

    assign pix_in.s_tready = ready;

    // -----------------------------------------------------------------------
    // Write path: one cycle from acceptance to the line buffer strobe
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_pixel_data       <= 8'h00;
            o_pixel_data_valid <= 1'b0;
        end else begin
            o_pixel_data_valid <= wr;
            if (wr) begin
                o_pixel_data <= pad_wr ? 8'h00 : pix_in.s_tdata;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Counters, credits and status flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_ctr      <= '0;
            line_ctr     <= '0;
            done_ctr     <= '0;
            credits      <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_frame_done <= drain_done;

            if (state_q == IDLE) begin
                if (i_start) begin
                    pix_ctr  <= '0;
                    line_ctr <= '0;
                    done_ctr <= '0;
                    credits  <= CRED_FULL;
                    o_busy   <= 1'b1;
                    o_err    <= 1'b0;
                end else if (i_line_done) begin
                    // Nothing is buffered while idle, so a returned line is bogus.
                    o_err <= 1'b1;
                end
            end else begin
                if (drain_done) begin
                    o_busy <= 1'b0;
                end

                if (wrap) begin
                    pix_ctr  <= '0;
                    line_ctr <= line_ctr + 1'b1;
                end else if (wr) begin
                    pix_ctr <= pix_ctr + 1'b1;
                end

                if (line_ret) begin
                    // Saturate rather than wrap on a misbehaving consumer.
                    if (done_ctr != '1) begin
                        done_ctr <= done_ctr + 1'b1;
                    end
                    if (credits == CRED_FULL) begin
                        o_err <= 1'b1;
                    end
                end

                // A returned line and a completed line in the same cycle
                // cancel; a return with every credit home is dropped.
                unique case ({line_ret, wrap})
                    2'b10: begin
                        if (credits != CRED_FULL) begin
                            credits <= credits + 1'b1;
                        end
                    end
                    2'b01: begin
                        credits <= credits - 1'b1;
                    end
                    default: begin
                        credits <= credits;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_feeder_credit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_feeder_credit_ctrl
//
// Self-checking bench for line_feeder_credit_ctrl (default build, no zero
// padding) with IMAGE_WIDTH=8, IMAGE_HEIGHT=6, BUF_LINES=4.
//
// The reference model tracks the frame as plain counts: lines written,
// pixels into the current line, credits returned and lines consumed. The
// available credit is derived arithmetically as
//   BUF_LINES + returned - lines_written
// and the expected write strobe/data follow one cycle after acceptance.
// ---------------------------------------------------------------------------
module tb_line_feeder_credit_ctrl;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int BUF = 4;
    localparam int LT  = H;
    localparam int DT  = LT - 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_start;
    logic       i_line_done;
    logic [7:0] o_pixel_data;
    logic       o_pixel_data_valid;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_err;

    line_feeder_credit_ctrl_if s_if ();

    line_feeder_credit_ctrl #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .BUF_LINES    (BUF)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .i_start            (i_start),
        .pix_in             (s_if),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .i_line_done        (i_line_done),
        .o_busy             (o_busy),
        .o_frame_done       (o_frame_done),
        .o_err              (o_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_busy, m_lines, m_pix, m_ret, m_dones, m_err, m_fd, m_valid, m_data;
    int acc_count;
    int data_salt;
    int vld_seen;
    int fd_seen;

    function automatic int credits_f();
        return BUF + m_ret - m_lines;
    endfunction

    function automatic bit ready_f();
        return (m_busy != 0) && (m_lines < LT) && (credits_f() > 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check ready mid-cycle, advance the model,
    // then check registered outputs just after the edge.
    task automatic step(input logic v, input logic ld, input logic st, input logic rn);
        logic [7:0] d;
        bit         acc;
        bit         wrap;
        int         cr;
        d = 8'(acc_count ^ data_salt);
        reset_n          = rn;
        i_start          = st;
        i_line_done      = ld;
        s_if.s_tvalid    = v;
        s_if.s_tdata     = d;
        #3;
        chk("s_tready", {31'd0, s_if.s_tready}, {31'd0, ready_f()});
        acc = v && ready_f();

        if (!rn) begin
            m_busy = 0; m_lines = 0; m_pix = 0; m_ret = 0; m_dones = 0;
            m_err = 0; m_fd = 0; m_valid = 0; m_data = 0;
        end else if (m_busy == 0) begin
            m_fd    = 0;
            m_valid = 0;
            if (st) begin
                m_busy = 1; m_lines = 0; m_pix = 0; m_ret = 0; m_dones = 0;
                m_err = 0; acc_count = 0;
            end else if (ld) begin
                m_err = 1;
            end
        end else begin
            cr   = credits_f();
            wrap = acc && (m_pix == W - 1);
            m_fd = (m_lines == LT && m_dones == DT) ? 1 : 0;
            if (m_fd != 0) m_busy = 0;
            if (ld) begin
                m_dones++;
                if (cr == BUF) m_err = 1;
                if (cr < BUF || wrap) m_ret++;
            end
            if (wrap) begin
                m_lines++;
                m_pix = 0;
            end else if (acc) begin
                m_pix++;
            end
            m_valid = acc ? 1 : 0;
            if (acc) begin
                m_data = int'(d);
                acc_count++;
            end
        end

        @(posedge clk);
        #1;
        chk("o_busy", {31'd0, o_busy}, 32'(m_busy));
        chk("o_frame_done", {31'd0, o_frame_done}, 32'(m_fd));
        chk("o_err", {31'd0, o_err}, 32'(m_err));
        chk("o_pixel_data_valid", {31'd0, o_pixel_data_valid}, 32'(m_valid));
        if (m_valid != 0) chk("o_pixel_data", {24'd0, o_pixel_data}, 32'(m_data));
        if (o_pixel_data_valid) vld_seen++;
        if (o_frame_done) fd_seen++;
    endtask

    // Run the current frame to completion with legal consumer returns.
    task automatic finish_frame(input bit rand_v, input int budget);
        int n;
        bit v;
        bit ld;
        n = 0;
        while (m_busy != 0 && n < budget) begin
            v  = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
            ld = (credits_f() < BUF) && (m_dones < DT) && ($urandom_range(0, 2) == 0);
            step(v, ld, 1'b0, 1'b1);
            n++;
        end
        chk("frame_complete_busy", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        int n;
        reset_n       = 1'b0;
        i_start       = 1'b0;
        i_line_done   = 1'b0;
        s_if.s_tvalid = 1'b0;
        s_if.s_tdata  = 8'h00;
        acc_count = 0; data_salt = 0; vld_seen = 0; fd_seen = 0;
        m_busy = 0; m_lines = 0; m_pix = 0; m_ret = 0; m_dones = 0;
        m_err = 0; m_fd = 0; m_valid = 0; m_data = 0;
        @(posedge clk);
        #1;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_data", {24'd0, o_pixel_data}, 32'd0);
        chk("reset_ready", {31'd0, s_if.s_tready}, 32'd0);

        // Idle: no acceptance before start
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        // 1) Up-front credits only: exactly 4 lines then stall
        step(1'b0, 1'b0, 1'b1, 1'b1);
        vld_seen = 0;
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t1_writes", 32'(vld_seen), 32'd32);
        chk("t1_stall_ready", {31'd0, s_if.s_tready}, 32'd0);
        chk("t1_busy", {31'd0, o_busy}, 32'd1);

        // 2) One credit returned: exactly one more line, then finish
        vld_seen = 0;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_one_more_line", 32'(vld_seen), 32'd8);
        fd_seen  = 0;
        vld_seen = 0;
        finish_frame(1'b0, 200);
        chk("t2_frame_done_pulses", 32'(fd_seen), 32'd1);
        chk("t2_last_line", 32'(vld_seen), 32'd8);

        // 3) Back-pressure with alternating valid, plus an ignored restart
        data_salt = int'($urandom_range(0, 255));
        step(1'b0, 1'b0, 1'b1, 1'b1);
        vld_seen = 0;
        for (int i = 0; i < 40; i++) step(i % 2 == 0, 1'b0, i == 7, 1'b1);
        chk("t3_accepted_beats", 32'(vld_seen), 32'd20);
        chk("t3_busy_after_restart", {31'd0, o_busy}, 32'd1);
        finish_frame(1'b1, 400);

        // 4) Line return coincident with a line-end wrap at credits==1
        data_salt = int'($urandom_range(0, 255));
        step(1'b0, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (!(m_lines == 3 && m_pix == W - 1) && n < 100) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            n++;
        end
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t4_err_clear", {31'd0, o_err}, 32'd0);
        chk("t4_ready_kept", {31'd0, s_if.s_tready}, 32'd1);
        vld_seen = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_one_line", 32'(vld_seen), 32'd8);
        finish_frame(1'b0, 200);

        // 5) Return with every credit home: sticky error until next start
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t5_err_set", {31'd0, o_err}, 32'd1);
        finish_frame(1'b1, 400);
        chk("t5_err_sticky", {31'd0, o_err}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5_err_cleared", {31'd0, o_err}, 32'd0);
        finish_frame(1'b1, 400);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t5_idle_err", {31'd0, o_err}, 32'd1);

        // 6) Reset while draining, then a clean frame
        step(1'b0, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (m_lines < LT && n < 300) begin
            step(1'($urandom_range(0, 1)),
                 (credits_f() < BUF) && (m_dones < DT - 1) && ($urandom_range(0, 1) == 0),
                 1'b0, 1'b1);
            n++;
        end
        chk("t6_in_drain", {31'd0, o_busy}, 32'd1);
        fd_seen = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_busy_low", {31'd0, o_busy}, 32'd0);
        chk("t6_ready_low", {31'd0, s_if.s_tready}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_no_frame_done", 32'(fd_seen), 32'd0);
        data_salt = int'($urandom_range(0, 255));
        step(1'b0, 1'b0, 1'b1, 1'b1);
        finish_frame(1'b1, 400);
        chk("t6_frame_done_after", 32'(fd_seen), 32'd1);

        // 7) A few fully random frames
        for (int f = 0; f < 3; f++) begin
            data_salt = int'($urandom_range(0, 255));
            step(1'b0, 1'b0, 1'b1, 1'b1);
            finish_frame(1'b1, 600);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
